// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port SPRAM (1-cycle synchronous read) between two req/gnt requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic pick_a;
  logic s1_rd, s1_port, s2_rd, s2_port;

`ifdef MEM_ARB_RR_EN
  // last_b set means B was granted last, so A wins the next contention
  logic last_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_b <= 1'b0;
    end else if (a_gnt || b_gnt) begin
      last_b <= b_gnt;
    end
  end

  assign pick_a = last_b;
`else
  assign pick_a = 1'b1;
`endif

  always_comb begin
    a_gnt = RST_N & a_req & (~b_req | pick_a);
    b_gnt = RST_N & b_req & (~a_req | ~pick_a);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr    <= '0;
      mem_write   <= 1'b0;
      mem_data_in <= '0;
      s1_rd       <= 1'b0;
      s1_port     <= 1'b0;
      s2_rd       <= 1'b0;
      s2_port     <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      mem_write <= 1'b0;
      s1_rd     <= 1'b0;
      if (a_gnt) begin
        mem_addr    <= a_addr;
        mem_write   <= a_we;
        mem_data_in <= a_wdata;
        s1_rd       <= ~a_we;
        s1_port     <= 1'b0;
      end else if (b_gnt) begin
        mem_addr    <= b_addr;
        mem_write   <= b_we;
        mem_data_in <= b_wdata;
        s1_rd       <= ~b_we;
        s1_port     <= 1'b1;
      end
      // Read data is on mem_data_out while the tag sits in stage 2
      s2_rd    <= s1_rd;
      s2_port  <= s1_port;
      a_rvalid <= s2_rd & ~s2_port;
      b_rvalid <= s2_rd & s2_port;
      if (s2_rd && !s2_port) a_rdata <= mem_data_out;
      if (s2_rd && s2_port)  b_rdata <= mem_data_out;
    end
  end

endmodule

`default_nettype wire
